// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU output stage.
//                flags_t     - packed {n, z, c, v} condition flags
//                stage_state_t - occupancy state of the output buffer
//                FLAG_*_IDX  - bit position of each flag inside flags_t
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int FLAG_N_IDX = 3;
   localparam int FLAG_Z_IDX = 2;
   localparam int FLAG_C_IDX = 1;
   localparam int FLAG_V_IDX = 0;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_flag_gen.sv
// ============================================================================
//  Module      : alu_flag_gen
//  Description : Combinational condition-flag generator for an upstream
//                shifter/ALU result.
//  Ports       : y_in  [N-1:0] in  - upstream result
//                c_in          in  - carry-out / last bit shifted out
//                v_in          in  - overflow
//                flags (flags_t) out - {n, z, c, v}
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] y_in,
   input  logic         c_in,
   input  logic         v_in,
   output flags_t       flags
);

   logic [3:0] w_bits;

   always_comb begin
      w_bits             = 4'b0000;
      w_bits[FLAG_N_IDX] = y_in[N-1];
      w_bits[FLAG_Z_IDX] = (y_in == '0);
      w_bits[FLAG_C_IDX] = c_in;
      w_bits[FLAG_V_IDX] = v_in;
      flags              = flags_t'(w_bits);
   end

endmodule

`default_nettype wire

// File: rtl/alu_output_stage.sv
// ============================================================================
//  Module      : alu_output_stage
//  Description : Registered valid/ready output stage for a shifter/ALU.
//                Captures the result plus generated flags and presents them
//                one cycle later, in FIFO order.
//  Config      : ALU_OUT_SKID_EN defined   -> 2-entry skid buffer,
//                                             registered in_ready
//                ALU_OUT_SKID_EN undefined -> 1-entry pipe register,
//                                             in_ready = empty || out_ready
//  Ports       : clk, reset (sync, active high)
//                in_valid / in_ready, y_in[N-1:0], c_in, v_in  - upstream
//                out_valid / out_ready, y[N-1:0], flags[3:0]    - downstream
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_output_stage
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] y_in,
   input  logic         c_in,
   input  logic         v_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] y,
   output logic [3:0]   flags
);

   logic          w_push;
   logic          w_pop;
   flags_t        w_in_flags;

   stage_state_t  state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [N-1:0]  head_y_q, head_y_d;
   flags_t        head_flags_q, head_flags_d;

   alu_flag_gen #(.N(N)) u_flag_gen (
      .y_in  (y_in),
      .c_in  (c_in),
      .v_in  (v_in),
      .flags (w_in_flags)
   );

   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign out_valid = (cnt_q != 2'd0);
   assign y         = head_y_q;
   assign flags     = head_flags_q;

   always_comb begin
      cnt_d = cnt_q;
      if (w_push && !w_pop)
         cnt_d = cnt_q + 2'd1;
      else if (!w_push && w_pop)
         cnt_d = cnt_q - 2'd1;
   end

`ifdef ALU_OUT_SKID_EN
   // The head entry drives the outputs; the skid entry absorbs the one
   // result that arrives while the head is stalled.
   logic [N-1:0]  skid_y_q, skid_y_d;
   flags_t        skid_flags_q, skid_flags_d;
   logic          in_ready_q, in_ready_d;

   assign in_ready = in_ready_q;

   always_comb begin
      state_d      = state_q;
      head_y_d     = head_y_q;
      head_flags_d = head_flags_q;
      skid_y_d     = skid_y_q;
      skid_flags_d = skid_flags_q;
      case (state_q)
         EMPTY: begin
            if (w_push) begin
               state_d      = ONE;
               head_y_d     = y_in;
               head_flags_d = w_in_flags;
            end
         end
         ONE: begin
            if (w_push && w_pop) begin
               head_y_d     = y_in;
               head_flags_d = w_in_flags;
            end else if (w_push) begin
               state_d      = FULL;
               skid_y_d     = y_in;
               skid_flags_d = w_in_flags;
            end else if (w_pop) begin
               state_d      = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only a pop can happen.
            if (w_pop) begin
               state_d      = ONE;
               head_y_d     = skid_y_q;
               head_flags_d = skid_flags_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Registered ready: reflects next-cycle occupancy.
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         skid_y_q     <= '0;
         skid_flags_q <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         skid_y_q     <= skid_y_d;
         skid_flags_q <= skid_flags_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   // A stalled result may be replaced in the same cycle it is consumed.
   assign in_ready = (state_q == EMPTY) || out_ready;

   always_comb begin
      state_d      = state_q;
      head_y_d     = head_y_q;
      head_flags_d = head_flags_q;
      if (w_push) begin
         state_d      = ONE;
         head_y_d     = y_in;
         head_flags_d = w_in_flags;
      end else if (w_pop) begin
         state_d      = EMPTY;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= EMPTY;
         cnt_q        <= 2'd0;
         head_y_q     <= '0;
         head_flags_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         head_y_q     <= head_y_d;
         head_flags_q <= head_flags_d;
      end
   end

endmodule

`default_nettype wire
